// File: rtl/additive_stream_decoder.sv
// rtl/additive_stream_decoder.sv - bit-serial running-key subtractor for the additive byte cipher
module additive_stream_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load,
    input  logic [WIDTH-1:0] key_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_borrow
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] key_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] r_sh_q;
    logic             borrow_q;
    logic             out_borrow_q;
    logic [CW-1:0]    count_q;

    logic             diff_d;
    logic             borrow_d;
    logic [WIDTH-1:0] a_sh_d;

    // Difference bits refill a_sh from the top as the minuend drains out the bottom,
    // so after WIDTH steps a_sh holds the full result.
    always_comb begin
        diff_d   = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
        borrow_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
        a_sh_d   = {diff_d, a_sh_q[WIDTH-1:1]};
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_data   = r_sh_q;
    assign out_borrow = out_borrow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            r_sh_q       <= '0;
            borrow_q     <= 1'b0;
            out_borrow_q <= 1'b0;
            count_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_load) begin
                        key_q <= key_in;
                    end
                    if (in_valid) begin
                        a_sh_q   <= in_data;
                        b_sh_q   <= key_load ? key_in : key_q;
                        borrow_q <= 1'b0;
                        count_q  <= '0;
                        state_q  <= S_SUB;
                    end
                end
                S_SUB: begin
                    a_sh_q   <= a_sh_d;
                    b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
                    borrow_q <= borrow_d;
                    count_q  <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        r_sh_q       <= a_sh_d;
                        out_borrow_q <= borrow_d;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        key_q   <= key_q + WIDTH'(1);
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_additive_stream_decoder.sv
// tb/tb_additive_stream_decoder.sv - scoreboard bench for additive_stream_decoder
module tb_additive_stream_decoder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_load = 1'b0;
    logic [W-1:0] key_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_borrow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] model_key = '0;
    logic [W:0]   exp_q[$];

    always #5 clk = ~clk;

    additive_stream_decoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_borrow(out_borrow)
    );

    // Presents one byte for exactly one accept edge; scoreboard gets the expected result.
    task automatic accept_byte(input logic [W-1:0] d, input logic ld, input logic [W-1:0] kin,
                               output bit to);
        logic [W-1:0] k;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        k = ld ? kin : model_key;
        if (ld) model_key = kin;
        exp_q.push_back({(d < k), W'(d - k)});
        in_valid = 1'b1;
        in_data  = d;
        key_load = ld;
        key_in   = kin;
        @(negedge clk);
        in_valid = 1'b0;
        key_load = 1'b0;
        in_data  = $urandom_range(0, 255);
        key_in   = $urandom_range(0, 255);
    endtask

    task automatic wait_valid(output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    // Samples the presented result, then handshakes it; the model key advances with the handshake.
    task automatic take_output(output logic [W-1:0] d, output logic b);
        d = out_data;
        b = out_borrow;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        model_key = model_key + W'(1);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        key_load  = 1'b1;
        key_in    = 8'h77;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        key_load  = 1'b0;
        out_ready = 1'b0;
        model_key = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || out_borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h brw=%b, need 1 0 00 0",
                     in_ready, out_valid, out_data, out_borrow);
        end
    endtask

    // One decode with latency, result, hold-in-IDLE and ready-after-handshake checks.
    task automatic run_one(input string name, input logic [W-1:0] d, input logic ld,
                           input logic [W-1:0] kin, input logic [W-1:0] want_d, input logic want_b);
        bit to;
        int lat;
        logic [W-1:0] gd;
        logic gb;
        logic [W:0] e;
        accept_byte(d, ld, kin, to);
        wait_valid(lat, to);
        n_checks++;
        if (to || lat != W) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles (timeout=%0b), need %0d", name, lat, to, W);
        end
        take_output(gd, gb);
        e = exp_q.pop_front();
        n_checks++;
        if (gd !== want_d || gb !== want_b || {gb, gd} !== e) begin
            n_fail++;
            $display("FAIL %s_result: got data=%h borrow=%b, need data=%h borrow=%b",
                     name, gd, gb, want_d, want_b);
        end
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== want_d || out_borrow !== want_b) begin
            n_fail++;
            $display("FAIL %s_idle_hold: got rdy=%b vld=%b data=%h brw=%b, need 1 0 %h %b",
                     name, in_ready, out_valid, out_data, out_borrow, want_d, want_b);
        end
    endtask

    task automatic test_basic();
        run_one("basic", 8'h4D, 1'b1, 8'h05, 8'h48, 1'b0);
    endtask

    task automatic test_follow_on();
        run_one("follow_zero", 8'h06, 1'b0, 8'h00, 8'h00, 1'b0);
        run_one("follow_under", 8'h00, 1'b0, 8'h00, 8'hF9, 1'b1);
    endtask

    task automatic test_key_wrap();
        run_one("load_ff", 8'h2A, 1'b1, 8'hFF, 8'h2B, 1'b1);
        run_one("after_wrap", 8'h33, 1'b0, 8'h00, 8'h33, 1'b0);
    endtask

    task automatic test_backpressure();
        bit to;
        int lat;
        logic [W-1:0] gd;
        logic gb;
        logic [W:0] e;
        accept_byte(8'hC3, 1'b0, 8'h00, to);
        wait_valid(lat, to);
        e = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom_range(0, 255);
            n_checks++;
            if (to || out_valid !== 1'b1 || in_ready !== 1'b0 || {out_borrow, out_data} !== e) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b brw=%b data=%h, need 1 0 %b %h",
                         i, out_valid, in_ready, out_borrow, out_data, e[W], e[W-1:0]);
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        take_output(gd, gb);
        e = exp_q.pop_front();
        n_checks++;
        if ({gb, gd} !== e) begin
            n_fail++;
            $display("FAIL bp_result: got %b/%h, need %b/%h", gb, gd, e[W], e[W-1:0]);
        end
        run_one("bp_key_next", 8'h10, 1'b0, 8'h00, 8'h10 - model_key, (8'h10 < model_key));
    endtask

    task automatic test_reset_mid_sub();
        bit to;
        int lat;
        accept_byte(8'h99, 1'b1, 8'h42, to);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_key = '0;
        exp_q.delete();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || out_borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy=%b vld=%b data=%h brw=%b, need 1 0 00 0",
                     in_ready, out_valid, out_data, out_borrow);
        end
        run_one("post_reset", 8'h10, 1'b0, 8'h00, 8'h10, 1'b0);
        // reset while a result waits in DONE must not advance the key either
        accept_byte(8'h20, 1'b0, 8'h00, to);
        wait_valid(lat, to);
        rst_n = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        model_key = '0;
        exp_q.delete();
        run_one("done_reset", 8'h21, 1'b0, 8'h00, 8'h21, 1'b0);
    endtask

    task automatic test_key_load_ignored();
        bit to;
        int lat;
        logic [W-1:0] gd;
        logic gb;
        logic [W:0] e;
        accept_byte(8'h50, 1'b1, 8'h13, to);
        key_load = 1'b1;
        key_in   = 8'hAA;
        wait_valid(lat, to);
        @(negedge clk);
        take_output(gd, gb);
        key_load = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (to || gd !== 8'h3D || gb !== 1'b0 || {gb, gd} !== e) begin
            n_fail++;
            $display("FAIL kl_ignored: got %b/%h, need 0/3d", gb, gd);
        end
        run_one("kl_key_next", 8'h14, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit to;
        int lat;
        logic [W-1:0] gd;
        logic gb;
        logic [W:0] e;
        for (int n = 0; n < 24; n++) begin
            logic ld;
            ld = ($urandom_range(0, 3) == 0);
            accept_byte(W'($urandom_range(0, 255)), ld, W'($urandom_range(0, 255)), to);
            wait_valid(lat, to);
            for (int s = $urandom_range(0, 2); s > 0; s--) @(negedge clk);
            take_output(gd, gb);
            e = exp_q.pop_front();
            n_checks++;
            if (to || {gb, gd} !== e) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %b/%h (timeout=%0b), need %b/%h",
                         n, gb, gd, to, e[W], e[W-1:0]);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_follow_on();
        test_key_wrap();
        test_backpressure();
        test_reset_mid_sub();
        test_key_load_ignored();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/additive_stream_decoder.md
# additive_stream_decoder

Bit-serial receive-side decoder for the team's additive byte cipher: each encoded byte was produced as plain + key (mod 2^WIDTH), with the key incrementing by one per byte. This block subtracts the running key one bit per clock through a single full-subtractor cell and a borrow flop, and returns the plain byte. It sits downstream of the encode datapath and uses valid/ready handshakes on both sides.

## Interface
- WIDTH, 8, data, key and shift-register width in bits (2..16)
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous, active-low
- key_load  input  1  load key_in into the running key (honoured only in IDLE)
- key_in  input  WIDTH  new key value
- in_valid  input  1  encoded byte present
- in_ready  output  1  block can accept a byte (high only in IDLE)
- in_data  input  WIDTH  encoded byte
- out_valid  output  1  decoded byte present (high only in DONE)
- out_ready  input  1  consumer accepts the decoded byte
- out_data  output  WIDTH  decoded byte = in_data - key mod 2^WIDTH
- out_borrow  output  1  final borrow; 1 when in_data < key (unsigned)

## Operation
- States: IDLE, SUB, DONE. Registers: key, a_sh (encoded byte), b_sh (key copy), r_sh (result), borrow, bit counter (ceil(log2 WIDTH)+1 bits).
- IDLE: in_ready=1. If key_load=1, key <= key_in. Accept on in_valid & in_ready: a_sh <= in_data, b_sh <= (key_load ? key_in : key), borrow <= 0, count <= 0, go to SUB.
- SUB: each cycle d = a_sh[0] ^ b_sh[0] ^ borrow; borrow <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow); d shifts into r_sh MSB, a_sh and b_sh shift right; count++. After the WIDTH-th bit go to DONE. in_data, in_valid, key_load, out_ready ignored.
- DONE: out_valid=1, out_data=r_sh, out_borrow=borrow, all held stable until out_ready=1. On out_valid & out_ready: key <= key + 1 (mod 2^WIDTH, 0xFF wraps to 0x00 for WIDTH=8), go to IDLE. key_load ignored in DONE.
- Key advances only on output handshake, never on accept or reset-abort.
- out_data and out_borrow keep their last value in IDLE/SUB (out_valid low).

## Timing
- Reset (rst_n low at an edge): state=IDLE, key=0, r_sh=0, borrow=0, count=0. Outputs after that edge: in_ready=1, out_valid=0, out_data=0, out_borrow=0. Reset wins over every other input in the same cycle.
- Reset mid-SUB or in DONE: byte discarded, no key advance, IDLE next cycle.
- Latency: accept at edge E0; bits computed at edges E1..E(WIDTH); out_valid high from E(WIDTH) on. With out_ready held high, return to IDLE at E(WIDTH+1); throughput one byte per WIDTH+2 cycles.
- in_ready is a decode of state (combinational, no input dependence); out_valid likewise.
- key_load and accept in the same IDLE cycle: the accepted byte uses key_in; key register also takes key_in.
- No output handshake is combinationally dependent on in_valid/out_ready.

## Test plan
- Reset then key_load key_in=0x05, feed 0x4D -> out_valid 8 cycles after accept, out_data=0x48, out_borrow=0; key becomes 0x06 after handshake.
- Follow-on byte 0x06 with key 0x06 -> out_data=0x00, out_borrow=0; then byte 0x00 with key 0x07 -> out_data=0xF9, out_borrow=1.
- key_load 0xFF with simultaneous accept of 0x2A -> out_data=0x2B, out_borrow=1; after handshake key=0x00 (wrap).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_data, out_borrow stable, in_ready=0, in_valid pulses ignored, key unchanged.
- Reset asserted at 3rd SUB cycle -> next cycle in_ready=1, out_valid=0, out_data=0, key=0; new byte 0x10 decodes to 0x10.
- key_load=1 in SUB/DONE with key_in=0xAA -> ignored; decoded result uses the key captured at accept.
